// File: rtl/bin2bcd_pkg.sv
// Shared state encoding and sizing helpers for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // floor(bin_w * log10(2)) + 1 decimal digits hold 2^bin_w - 1.
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of shift-and-add-3: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter, one input bit per clock.
// BIN2BCD_SIGNED_EN: treat bin as two's complement, convert |bin| and report the sign on bcd_neg.
module bin2bcd_iter
  import bin2bcd_pkg::*;
#(
  parameter  int BIN_W   = 11,
  localparam int BCD_DIG = bcd_digits(BIN_W)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [BIN_W-1:0]         bin,
  input  logic                     bin_vld,
  output logic                     bin_rdy,
  output logic [BCD_W*BCD_DIG-1:0] bcd,
  output logic                     bcd_vld,
  input  logic                     bcd_rdy
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                     bcd_neg
`endif
);

  localparam int DIG_W = BCD_W * BCD_DIG;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]       state;
  logic [BIN_W-1:0] sh;
  logic [DIG_W-1:0] dig;
  logic [DIG_W-1:0] dig_adj;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] load_val;

  // A transfer happens on any edge where valid and ready are both high;
  // valid may rise at any time, ready is purely a function of the state.
  assign bin_rdy = (state == IDLE);
  assign bcd_vld = (state == DONE);
  assign bcd     = dig;

`ifdef BIN2BCD_SIGNED_EN
  logic neg;
  // -(-2^(BIN_W-1)) wraps to 2^(BIN_W-1), which is the correct unsigned magnitude.
  assign load_val = bin[BIN_W-1] ? -bin : bin;
  assign bcd_neg  = neg;
`else
  assign load_val = bin;
`endif

  for (genvar g = 0; g < BCD_DIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (dig[BCD_W*g +: BCD_W]),
      .q (dig_adj[BCD_W*g +: BCD_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      sh    <= '0;
      dig   <= '0;
      cnt   <= '0;
`ifdef BIN2BCD_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bin_vld) begin
            sh    <= load_val;
            dig   <= '0;
            cnt   <= '0;
`ifdef BIN2BCD_SIGNED_EN
            neg   <= bin[BIN_W-1];
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Iterations run for cnt = 0..BIN_W-1; the cycle seeing cnt == BIN_W only hands over to DONE.
          if (cnt == CNT_W'(BIN_W)) begin
            state <= DONE;
          end else begin
            {dig, sh} <= {dig_adj, sh} << 1;
            cnt       <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bcd_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Bench for bin2bcd_iter at BIN_W = 11, 4 and 20, checked against a decimal reference model.
module tb_bin2bcd_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int n_cmp = 0;
  int n_err = 0;

  // BIN_W = 11 instance
  logic [10:0] bin;
  logic        bin_vld, bin_rdy;
  logic [15:0] bcd;
  logic        bcd_vld, bcd_rdy, bcd_neg;

  // BIN_W = 4 instance
  logic [3:0]  b4_bin;
  logic        b4_vld, b4_rdy;
  logic [7:0]  b4_bcd;
  logic        b4_bvld, b4_brdy, b4_neg;

  // BIN_W = 20 instance
  logic [19:0] b20_bin;
  logic        b20_vld, b20_rdy;
  logic [27:0] b20_bcd;
  logic        b20_bvld, b20_brdy, b20_neg;

  bin2bcd_iter #(.BIN_W(11)) dut (
    .clk(clk), .rstn(rstn), .bin(bin), .bin_vld(bin_vld), .bin_rdy(bin_rdy),
    .bcd(bcd), .bcd_vld(bcd_vld), .bcd_rdy(bcd_rdy)
`ifdef BIN2BCD_SIGNED_EN
    , .bcd_neg(bcd_neg)
`endif
  );

  bin2bcd_iter #(.BIN_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .bin(b4_bin), .bin_vld(b4_vld), .bin_rdy(b4_rdy),
    .bcd(b4_bcd), .bcd_vld(b4_bvld), .bcd_rdy(b4_brdy)
`ifdef BIN2BCD_SIGNED_EN
    , .bcd_neg(b4_neg)
`endif
  );

  bin2bcd_iter #(.BIN_W(20)) dut20 (
    .clk(clk), .rstn(rstn), .bin(b20_bin), .bin_vld(b20_vld), .bin_rdy(b20_rdy),
    .bcd(b20_bcd), .bcd_vld(b20_bvld), .bcd_rdy(b20_brdy)
`ifdef BIN2BCD_SIGNED_EN
    , .bcd_neg(b20_neg)
`endif
  );

`ifndef BIN2BCD_SIGNED_EN
  assign bcd_neg = 1'b0;
  assign b4_neg  = 1'b0;
  assign b20_neg = 1'b0;
`endif

  // Reference: interpret the w-bit value (signed when enabled), take its magnitude, emit decimal digits.
  function automatic logic [63:0] ref_bcd(input longint unsigned raw, input int w);
    longint unsigned mag;
    logic [63:0] r;
    mag = raw & ((64'd1 << w) - 64'd1);
`ifdef BIN2BCD_SIGNED_EN
    if (mag >= (64'd1 << (w - 1))) mag = (64'd1 << w) - mag;
`endif
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  function automatic logic ref_neg(input longint unsigned raw, input int w);
`ifdef BIN2BCD_SIGNED_EN
    return ((raw >> (w - 1)) & 64'd1) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic convert_main(input logic [10:0] v, output logic [15:0] res, output logic neg,
                              output int lat);
    int n = 0;
    while (!bin_rdy && n < 50) begin @(posedge clk); #1; n++; end
    bin = v; bin_vld = 1'b1;
    @(posedge clk); #1;
    bin_vld = 1'b0;
    bin = 11'($urandom);
    lat = 0;
    while (!bcd_vld && lat < 50) begin @(posedge clk); #1; lat++; end
    res = bcd; neg = bcd_neg;
    bcd_rdy = 1'b1;
    @(posedge clk); #1;
    bcd_rdy = 1'b0;
  endtask

  task automatic run_small(input int w, input logic [19:0] v, output logic [27:0] res,
                           output logic neg, output int lat);
    int n = 0;
    while (!(w == 4 ? b4_rdy : b20_rdy) && n < 50) begin @(posedge clk); #1; n++; end
    if (w == 4) begin b4_bin = v[3:0]; b4_vld = 1'b1; end
    else begin b20_bin = v; b20_vld = 1'b1; end
    @(posedge clk); #1;
    b4_vld = 1'b0; b20_vld = 1'b0;
    lat = 0;
    while (!(w == 4 ? b4_bvld : b20_bvld) && lat < 50) begin @(posedge clk); #1; lat++; end
    res = (w == 4) ? {20'b0, b4_bcd} : b20_bcd;
    neg = (w == 4) ? b4_neg : b20_neg;
    if (w == 4) b4_brdy = 1'b1; else b20_brdy = 1'b1;
    @(posedge clk); #1;
    b4_brdy = 1'b0; b20_brdy = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (bin_rdy !== 1'b1 || bcd_vld !== 1'b0 || bcd !== 16'h0 || bcd_neg !== 1'b0) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b bcd=%h neg=%b, want 1 0 0000 0", bin_rdy, bcd_vld, bcd, bcd_neg);
    end
    n_cmp++;
    if (b4_rdy !== 1'b1 || b4_bvld !== 1'b0 || b20_rdy !== 1'b1 || b20_bvld !== 1'b0 ||
        b4_bcd !== 8'h0 || b20_bcd !== 28'h0) begin
      n_err++;
      $display("FAIL reset_small: rdy4=%b vld4=%b rdy20=%b vld20=%b, want 1 0 1 0", b4_rdy, b4_bvld,
               b20_rdy, b20_bvld);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_vectors();
    logic [10:0] vin[$];
    logic [15:0] vout[$];
    logic        vneg[$];
    logic [15:0] res;
    logic        neg;
    int          lat;
`ifdef BIN2BCD_SIGNED_EN
    vin  = '{11'h79C, 11'h400, 11'h3FF};
    vout = '{16'h0100, 16'h1024, 16'h1023};
    vneg = '{1'b1, 1'b1, 1'b0};
`else
    vin  = '{11'h79C, 11'h724, 11'h0FF, 11'h000, 11'h7FF};
    vout = '{16'h1948, 16'h1828, 16'h0255, 16'h0000, 16'h2047};
    vneg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    foreach (vin[i]) begin
      convert_main(vin[i], res, neg, lat);
      n_cmp++;
      if (res !== vout[i] || neg !== vneg[i]) begin
        n_err++;
        $display("FAIL spec_vec %h: bcd=%h neg=%b, want %h %b", vin[i], res, neg, vout[i], vneg[i]);
      end
      n_cmp++;
      if (lat !== 12) begin
        n_err++;
        $display("FAIL latency %h: %0d edges, want 12", vin[i], lat);
      end
    end
  endtask

  task automatic test_random_main();
    logic [10:0] v;
    logic [15:0] res;
    logic [63:0] e;
    logic        neg;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      v = 11'($urandom_range(0, 2047));
      e = ref_bcd({53'b0, v}, 11);
      convert_main(v, res, neg, lat);
      n_cmp++;
      if (res !== e[15:0] || neg !== ref_neg({53'b0, v}, 11) || lat !== 12) begin
        n_err++;
        $display("FAIL random11 %h: bcd=%h neg=%b lat=%0d, want %h %b 12", v, res, neg, lat, e[15:0],
                 ref_neg({53'b0, v}, 11));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    int n;
    bin = 11'h0FF; bin_vld = 1'b1;
    @(posedge clk); #1;
    // Second operand presented while busy; must wait until the converter is idle again.
    bin = 11'h724;
    n = 0;
    while (!bcd_vld && n < 50) begin
      n_cmp++;
      if (bin_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_rdy: rdy=%b, want 0", bin_rdy); end
      @(posedge clk); #1; n++;
    end
    e = ref_bcd(64'h0FF, 11);
    n_cmp++;
    if (bcd !== e[15:0] || bcd_vld !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: bcd=%h vld=%b, want %h 1", bcd, bcd_vld, e[15:0]);
    end
    bcd_rdy = 1'b1;
    @(posedge clk); #1;
    bcd_rdy = 1'b0;
    n_cmp++;
    if (bin_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_back: rdy=%b, want 1", bin_rdy); end
    @(posedge clk); #1;
    bin_vld = 1'b0;
    n = 0;
    while (!bcd_vld && n < 50) begin @(posedge clk); #1; n++; end
    e = ref_bcd(64'h724, 11);
    n_cmp++;
    if (bcd !== e[15:0] || bcd_neg !== ref_neg(64'h724, 11) || n !== 12) begin
      n_err++;
      $display("FAIL b2b_second: bcd=%h neg=%b lat=%0d, want %h %b 12", bcd, bcd_neg, n, e[15:0],
               ref_neg(64'h724, 11));
    end
    bcd_rdy = 1'b1;
    @(posedge clk); #1;
    bcd_rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [10:0] v, other;
    logic [15:0] hold;
    logic [63:0] e;
    int n;
    v = 11'($urandom_range(0, 2047));
    other = 11'($urandom_range(0, 2047));
    // Early ready before any result must not matter.
    bcd_rdy = 1'b1;
    bin = v; bin_vld = 1'b1;
    @(posedge clk); #1;
    bin_vld = 1'b0; bcd_rdy = 1'b0;
    n = 0;
    while (!bcd_vld && n < 50) begin @(posedge clk); #1; n++; end
    hold = bcd;
    e = ref_bcd({53'b0, v}, 11);
    n_cmp++;
    if (hold !== e[15:0] || n !== 12) begin
      n_err++;
      $display("FAIL bp_result %h: bcd=%h lat=%0d, want %h 12", v, hold, n, e[15:0]);
    end
    bin = other; bin_vld = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bcd_vld !== 1'b1 || bin_rdy !== 1'b0 || bcd !== hold) begin
        n_err++;
        $display("FAIL bp_hold: vld=%b rdy=%b bcd=%h, want 1 0 %h", bcd_vld, bin_rdy, bcd, hold);
      end
    end
    bcd_rdy = 1'b1;
    @(posedge clk); #1;
    bcd_rdy = 1'b0;
    n_cmp++;
    if (bin_rdy !== 1'b1 || bcd_vld !== 1'b0 || bcd !== hold) begin
      n_err++;
      $display("FAIL bp_release: rdy=%b vld=%b bcd=%h, want 1 0 %h", bin_rdy, bcd_vld, bcd, hold);
    end
    @(posedge clk); #1;
    bin_vld = 1'b0;
    n = 0;
    while (!bcd_vld && n < 50) begin @(posedge clk); #1; n++; end
    e = ref_bcd({53'b0, other}, 11);
    n_cmp++;
    if (bcd !== e[15:0]) begin
      n_err++;
      $display("FAIL bp_held_operand %h: bcd=%h, want %h", other, bcd, e[15:0]);
    end
    bcd_rdy = 1'b1;
    @(posedge clk); #1;
    bcd_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] res;
    logic [63:0] e;
    logic        neg;
    int          lat;
    bin = 11'h7FF; bin_vld = 1'b1;
    @(posedge clk); #1;
    bin_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bcd_vld !== 1'b0 || bin_rdy !== 1'b1 || bcd !== 16'h0 || bcd_neg !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: vld=%b rdy=%b bcd=%h neg=%b, want 0 1 0000 0", bcd_vld, bin_rdy, bcd,
               bcd_neg);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    convert_main(11'h3E8, res, neg, lat);
    e = ref_bcd(64'h3E8, 11);
    n_cmp++;
    if (res !== e[15:0] || lat !== 12) begin
      n_err++;
      $display("FAIL after_reset 3E8: bcd=%h lat=%0d, want %h 12", res, lat, e[15:0]);
    end
  endtask

  task automatic test_width4();
    logic [27:0] res;
    logic [63:0] e;
    logic        neg;
    int          lat;
    for (int v = 0; v < 16; v++) begin
      run_small(4, 20'(v), res, neg, lat);
      e = ref_bcd(64'(v), 4);
      n_cmp++;
      if (res[7:0] !== e[7:0] || neg !== ref_neg(64'(v), 4) || lat !== 5) begin
        n_err++;
        $display("FAIL w4 %0d: bcd=%h neg=%b lat=%0d, want %h %b 5", v, res[7:0], neg, lat, e[7:0],
                 ref_neg(64'(v), 4));
      end
    end
  endtask

  task automatic test_width20();
    logic [19:0] v;
    logic [27:0] res;
    logic [63:0] e;
    logic        neg;
    int          lat;
    run_small(20, 20'hFFFFF, res, neg, lat);
    n_cmp++;
`ifdef BIN2BCD_SIGNED_EN
    if (res !== 28'h0000001 || neg !== 1'b1) begin
      n_err++;
      $display("FAIL w20_max: bcd=%h neg=%b, want 0000001 1", res, neg);
    end
`else
    if (res !== 28'h1048575 || neg !== 1'b0) begin
      n_err++;
      $display("FAIL w20_max: bcd=%h neg=%b, want 1048575 0", res, neg);
    end
`endif
    for (int i = 0; i < 1000; i++) begin
      v = 20'($urandom);
      run_small(20, v, res, neg, lat);
      e = ref_bcd({44'b0, v}, 20);
      n_cmp++;
      if (res !== e[27:0] || neg !== ref_neg({44'b0, v}, 20) || lat !== 21) begin
        n_err++;
        $display("FAIL w20 %h: bcd=%h neg=%b lat=%0d, want %h %b 21", v, res, neg, lat, e[27:0],
                 ref_neg({44'b0, v}, 20));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    bin = '0; bin_vld = 1'b0; bcd_rdy = 1'b0;
    b4_bin = '0; b4_vld = 1'b0; b4_brdy = 1'b0;
    b20_bin = '0; b20_vld = 1'b0; b20_brdy = 1'b0;
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random_main();
    test_width4();
    test_width20();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
